io_responder: RTL and testbench
===============================

// Module: io_responder
// PURPOSE
// - MMIO slave answering the CPU's IORead/IOWrite strobes (address[31:10] all ones = I/O space).
// - Holds the LED output register, a synchronised/debounced switch input with a sticky change flag,
//   and a free-running microsecond timer.
// - Sits between the CPU datapath's memory/IO mux and the board pins.
// - Read data is combinational from registers, so it is valid in the same cycle as a single-cycle lw.
// PARAMETERS
// - SW_WIDTH         24      switch input width (<=32)
// - LED_WIDTH        24      LED output width (<=32)
// - DEBOUNCE_CYCLES  100000  stable cycles required before a switch change is accepted (>=2)
// - PRESCALE         100     clock cycles per timer tick (>=1)
// PORTS
// - clock       in   1          single system clock, rising edge
// - reset       in   1          synchronous, active-high
// - IORead      in   1          I/O load this cycle
// - IOWrite     in   1          I/O store this cycle
// - addr_low    in   10         address[9:0], byte address
// - wdata       in   32         store data
// - rdata       out  32         load data (combinational)
// - switch_in   in   SW_WIDTH   raw asynchronous board switches
// - led_out     out  LED_WIDTH  LED pins, registered
// BEHAVIOUR
// - Register map (addr_low):
//   - 0x060 LED (R/W)
//   - 0x070 SW (RO, debounced value, zero-extended)
//   - 0x074 STATUS (RO, bit0 = sw_changed sticky; a read clears it)
//   - 0x080 TIMER count (R/W)
//   - 0x084 TIMER ctrl (R/W, bit0 = run)
// - Unmapped or misaligned (addr_low[1:0]!=0) accesses: write ignored, rdata = 0.
// - Writes commit on the rising edge while IOWrite=1; LED takes wdata[LED_WIDTH-1:0].
// - rdata = 0 whenever IORead=0.
// - If IORead and IOWrite are both 1: the write commits and rdata shows the pre-write value.
// - Switch path:
//   - 2-flop synchroniser on switch_in.
//   - Debounce FSM, states STABLE and SETTLE.
//   - STABLE -> SETTLE when sync != debounced; the counter loads 0.
//   - In SETTLE the counter increments each cycle while sync equals the captured candidate.
//   - Candidate changes in SETTLE: counter restarts at 0 with the new candidate.
//   - sync returns to the debounced value: back to STABLE, no update.
//   - Counter reaches DEBOUNCE_CYCLES-1: debounced <= candidate, sw_changed <= 1, -> STABLE.
//   - Same-cycle STATUS read-clear and new set of sw_changed: the set wins.
// - Timer: prescaler counts 0..PRESCALE-1 while run=1; at wrap, count +1 (32-bit, wraps to 0 silently).
//   - A CPU write to TIMER count in the same cycle as a tick wins; the prescaler resets to 0.
//   - run=0 freezes both the count and the prescaler.
// - Reset values:
//   - led_out=0, debounced=0, sw_changed=0, FSM=STABLE, synchroniser=0.
//   - Timer count=0, prescaler=0, run=0.
//   - rdata follows from these.
//   - Reset mid-debounce abandons the candidate.
// - Latency: write->led_out 1 cycle; switch_in->SW read 2+DEBOUNCE_CYCLES cycles.
// CONFIGURATION
// - TIMER_EN defined: timer registers present as above.
// - TIMER_EN undefined:
//   - No timer or prescaler logic.
//   - 0x080 and 0x084 behave as unmapped (read 0, writes ignored).
// TESTING (bench: DEBOUNCE_CYCLES=4, PRESCALE=3, TIMER_EN defined)
// - Reset held 2 cycles -> led_out=0, read 0x070=0, 0x074=0, 0x080=0.
// - IOWrite 0x060 wdata=0xA5A5A5A5 -> next cycle led_out=0xA5A5A5; read 0x060 = 0x00A5A5A5.
// - switch_in 0->0x000003 held -> SW reads 0 until cycle 2+4, then 0x3.
//   - STATUS reads 1 once, then 0.
// - switch glitch 0x1 for 2 cycles then back to 0 -> SW stays 0, STATUS stays 0.
// - Write ctrl=1, wait 9 cycles -> count=3.
//   - Write count=0xFFFFFFFF, wait 3 cycles -> count=0.
//   - Write ctrl=0 -> count frozen.
// - Read 0x3FC and 0x062 -> rdata=0; write 0x3FC -> no register changes.
//   - IORead=0 with addr_low=0x060 -> rdata=0.

Source files
------------

// File: rtl/io_responder.sv
// MMIO I/O-space slave: LED register, debounced switches with sticky change flag, optional microsecond timer (`TIMER_EN).
// Latency: reads combinational, writes commit next edge; switch_in -> SW read 2+DEBOUNCE_CYCLES cycles.
// Backpressure: none, every IORead/IOWrite strobe is serviced in the cycle it is presented.
module io_responder #(
    parameter int SW_WIDTH        = 24,
    parameter int LED_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PRESCALE        = 100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 IORead,
    input  logic                 IOWrite,
    input  logic [9:0]           addr_low,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [SW_WIDTH-1:0]  switch_in,
    output logic [LED_WIDTH-1:0] led_out
);
    localparam logic [9:0] ADDR_LED    = 10'h060;
    localparam logic [9:0] ADDR_SW     = 10'h070;
    localparam logic [9:0] ADDR_STATUS = 10'h074;
    localparam logic [9:0] ADDR_TCOUNT = 10'h080;
    localparam logic [9:0] ADDR_TCTRL  = 10'h084;

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);

    logic [SW_WIDTH-1:0] sync1, sync2, debounced, candidate;
    logic [0:0]          db_state;
    logic [DCW-1:0]      db_cnt;
    logic                sw_changed;
    logic                status_rd;
    logic                led_wr;
    logic                wdata_unused;

    assign status_rd    = IORead && (addr_low == ADDR_STATUS);
    assign led_wr       = IOWrite && (addr_low == ADDR_LED);
    assign wdata_unused = ^wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_out <= '0;
        end else if (led_wr) begin
            led_out <= wdata[LED_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_in;
            sync2 <= sync1;
        end
    end

    // A candidate is accepted on the edge its stable run reaches DEBOUNCE_CYCLES samples,
    // i.e. when the counter would step to DEBOUNCE_CYCLES-1. A new set overrides a read-clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_state   <= ST_STABLE;
            db_cnt     <= '0;
            candidate  <= '0;
            debounced  <= '0;
            sw_changed <= 1'b0;
        end else begin
            if (status_rd) begin
                sw_changed <= 1'b0;
            end
            case (db_state)
                ST_STABLE: begin
                    if (sync2 != debounced) begin
                        db_state  <= ST_SETTLE;
                        candidate <= sync2;
                        db_cnt    <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (sync2 == debounced) begin
                        db_state <= ST_STABLE;
                    end else if (sync2 != candidate) begin
                        candidate <= sync2;
                        db_cnt    <= '0;
                    end else if (db_cnt == DCW'(DEBOUNCE_CYCLES - 2)) begin
                        debounced  <= candidate;
                        sw_changed <= 1'b1;
                        db_state   <= ST_STABLE;
                    end else begin
                        db_cnt <= db_cnt + DCW'(1);
                    end
                end
                default: db_state <= ST_STABLE;
            endcase
        end
    end

`ifdef TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [31:0]   t_count;
    logic [PW-1:0] t_pre;
    logic          t_run;

    always_ff @(posedge clock) begin
        if (reset) begin
            t_count <= '0;
            t_pre   <= '0;
            t_run   <= 1'b0;
        end else begin
            if (IOWrite && (addr_low == ADDR_TCTRL)) begin
                t_run <= wdata[0];
            end
            if (IOWrite && (addr_low == ADDR_TCOUNT)) begin
                t_count <= wdata;
                t_pre   <= '0;
            end else if (t_run) begin
                if (t_pre == PW'(PRESCALE - 1)) begin
                    t_pre   <= '0;
                    t_count <= t_count + 32'd1;
                end else begin
                    t_pre <= t_pre + PW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (IORead) begin
            case (addr_low)
                ADDR_LED:    rdata = 32'(led_out);
                ADDR_SW:     rdata = 32'(debounced);
                ADDR_STATUS: rdata = {31'b0, sw_changed};
`ifdef TIMER_EN
                ADDR_TCOUNT: rdata = t_count;
                ADDR_TCTRL:  rdata = {31'b0, t_run};
`endif
                default:     rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed steps plus randomized traffic against a behavioural model.
module tb_io_responder;
    localparam int D    = 4;
    localparam int P    = 3;
    localparam int SWW  = 24;
    localparam int LEDW = 24;

    logic            clock = 1'b0;
    logic            reset;
    logic            IORead, IOWrite;
    logic [9:0]      addr_low;
    logic [31:0]     wdata, rdata;
    logic [SWW-1:0]  switch_in;
    logic [LEDW-1:0] led_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    io_responder #(
        .SW_WIDTH(SWW), .LED_WIDTH(LEDW), .DEBOUNCE_CYCLES(D), .PRESCALE(P)
    ) dut (
        .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
        .addr_low(addr_low), .wdata(wdata), .rdata(rdata),
        .switch_in(switch_in), .led_out(led_out)
    );

    // Reference model: switch accepted once the synchronised value has held a non-debounced
    // value for D consecutive samples; timer = base + running cycles / P.
    logic [LEDW-1:0] m_led;
    logic [SWW-1:0]  m_s1, m_s2, m_deb, m_runval;
    int              m_runlen;
    logic            m_changed;
    logic [31:0]     m_base;
    int unsigned     m_rc;
    logic            m_run;

    function automatic logic [31:0] mread(input logic [9:0] a);
        case (a)
            10'h060: return 32'(m_led);
            10'h070: return 32'(m_deb);
            10'h074: return {31'b0, m_changed};
`ifdef TIMER_EN
            10'h080: return m_base + 32'(m_rc / P);
            10'h084: return {31'b0, m_run};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic set;
        if (reset) begin
            m_led = '0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_runval = '0;
            m_runlen = 0; m_changed = 1'b0; m_base = '0; m_rc = 0; m_run = 1'b0;
        end else begin
            set = 1'b0;
            if (IOWrite && addr_low == 10'h060) m_led = wdata[LEDW-1:0];
            if (m_s2 == m_deb) begin
                m_runlen = 0;
            end else if (m_runlen > 0 && m_s2 == m_runval) begin
                m_runlen++;
            end else begin
                m_runval = m_s2;
                m_runlen = 1;
            end
            if (m_runlen == D) begin
                m_deb = m_s2;
                m_runlen = 0;
                set = 1'b1;
            end
            if (set) m_changed = 1'b1;
            else if (IORead && addr_low == 10'h074) m_changed = 1'b0;
            if (IOWrite && addr_low == 10'h080) begin
                m_base = wdata;
                m_rc = 0;
            end else if (m_run) begin
                m_rc++;
            end
            if (IOWrite && addr_low == 10'h084) m_run = wdata[0];
            m_s2 = m_s1;
            m_s1 = switch_in;
        end
        @(posedge clock);
        #1;
        check("led_out", 32'(led_out), 32'(m_led));
    endtask

    task automatic rd(input string tag, input logic [9:0] a, output logic [31:0] obs);
        IORead = 1'b1; IOWrite = 1'b0; addr_low = a;
        #1;
        obs = rdata;
        check(tag, obs, mread(a));
        cycle();
        IORead = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        IOWrite = 1'b1; IORead = 1'b0; addr_low = a; wdata = d;
        cycle();
        IOWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] obs;
        logic [9:0]  addrs [8];
        addrs = '{10'h060, 10'h070, 10'h074, 10'h080, 10'h084, 10'h062, 10'h3FC, 10'h000};

        reset = 1'b1; IORead = 1'b0; IOWrite = 1'b0; addr_low = '0; wdata = '0; switch_in = '0;
        cycle();
        cycle();
        reset = 1'b0;

        check("rst_led", 32'(led_out), 32'h0);
        rd("rst_sw", 10'h070, obs);      check("rst_sw_lit", obs, 32'h0);
        rd("rst_status", 10'h074, obs);  check("rst_status_lit", obs, 32'h0);
        rd("rst_timer", 10'h080, obs);   check("rst_timer_lit", obs, 32'h0);

        wr(10'h060, 32'hA5A5A5A5);
        check("led_wr_lit", 32'(led_out), 32'h00A5A5A5);
        rd("led_rd", 10'h060, obs);      check("led_rd_lit", obs, 32'h00A5A5A5);

        switch_in = 24'h000003;
        for (int k = 1; k <= 8; k++) begin
            rd($sformatf("sw_k%0d", k), 10'h070, obs);
            check($sformatf("sw_lit_k%0d", k), obs, (k >= 7) ? 32'h3 : 32'h0);
        end
        rd("status_set", 10'h074, obs);  check("status_set_lit", obs, 32'h1);
        rd("status_clr", 10'h074, obs);  check("status_clr_lit", obs, 32'h0);

        switch_in = '0;
        repeat (8) cycle();
        rd("status_back", 10'h074, obs);
        switch_in = 24'h000001;
        cycle();
        cycle();
        switch_in = '0;
        for (int k = 0; k < 8; k++) begin
            rd("glitch_sw", 10'h070, obs); check("glitch_sw_lit", obs, 32'h0);
        end
        rd("glitch_status", 10'h074, obs); check("glitch_status_lit", obs, 32'h0);

        wr(10'h084, 32'h1);
        repeat (9) cycle();
        rd("timer_run", 10'h080, obs);
`ifdef TIMER_EN
        check("timer_run_lit", obs, 32'h3);
`endif
        wr(10'h080, 32'hFFFFFFFF);
        repeat (3) cycle();
        rd("timer_wrap", 10'h080, obs);
`ifdef TIMER_EN
        check("timer_wrap_lit", obs, 32'h0);
`endif
        wr(10'h084, 32'h0);
        rd("timer_stop", 10'h080, obs);
        repeat (5) cycle();
        rd("timer_frozen", 10'h080, obs);
        rd("timer_ctrl", 10'h084, obs);

        rd("unmapped_3fc", 10'h3FC, obs); check("unmapped_3fc_lit", obs, 32'h0);
        rd("misaligned_062", 10'h062, obs); check("misaligned_062_lit", obs, 32'h0);
        wr(10'h3FC, 32'hFFFFFFFF);
        wr(10'h062, 32'h00FFFFFF);
        check("unmapped_wr_led", 32'(led_out), 32'h00A5A5A5);
        IORead = 1'b0; addr_low = 10'h060;
        #1;
        check("no_ioread", rdata, 32'h0);

        IORead = 1'b1; IOWrite = 1'b1; addr_low = 10'h060; wdata = 32'h12345678;
        #1;
        check("rw_pre", rdata, 32'h00A5A5A5);
        cycle();
        IORead = 1'b0; IOWrite = 1'b0;
        check("rw_post_lit", 32'(led_out), 32'h00345678);

        switch_in = 24'h000005;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rd("mid_rst_sw", 10'h070, obs); check("mid_rst_sw_lit", obs, 32'h0);
        switch_in = '0;
        repeat (4) cycle();

        for (int i = 0; i < 400; i++) begin
            int op;
            logic [9:0] a;
            op = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 7)];
            case (op)
                0: wr(10'h060, $urandom());
                1, 2: begin
                    switch_in = ($urandom_range(0, 3) == 0) ? SWW'($urandom()) : SWW'($urandom_range(0, 3));
                    repeat ($urandom_range(1, 7)) cycle();
                end
                3, 4, 5: rd("rand_rd", a, obs);
                6: begin
                    if ($urandom_range(0, 1) == 0) wr(10'h080, $urandom());
                    else wr(10'h084, 32'($urandom_range(0, 1)));
                end
                7: begin
                    IORead = 1'b1; IOWrite = 1'b1; addr_low = a; wdata = $urandom();
                    #1;
                    check("rand_rw", rdata, mread(a));
                    cycle();
                    IORead = 1'b0; IOWrite = 1'b0;
                end
                8: wr(($urandom_range(0, 1) == 0) ? 10'h3FC : 10'h061, $urandom());
                default: cycle();
            endcase
        end
        rd("final_sw", 10'h070, obs);
        rd("final_timer", 10'h080, obs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
